// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and glyph table for the seg7_scan display driver.
// Segment order is gfedcba, logical active-high (bit0 = a).
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam seg_t SEG_BLANK = 7'h00;

  // Index 15 (F) first, index 0 (0) last.
  localparam logic [15:0][6:0] SEG7_LUT = {
    7'h71, 7'h79, 7'h5E, 7'h39,
    7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66,
    7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational nibble to 7-segment glyph decoder.
// Output is logical active-high; pin polarity is applied by the caller.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output seg_t       o_seg
);

  assign o_seg = SEG7_LUT[i_nib];

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: multiplexed 7-seg scanner with frame-boundary digit update.
// Optional leading-zero blanking when SEG7_SCAN_LZB_EN is defined.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int REFRESH_DIV    = 1000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  output logic [DIGITS-1:0]     an,
  output seg_t                  seg,
  output logic                  dp,
  output logic                  frame_done
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(DIGITS);

  localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

  // XOR masks: pin value of an "off" output under each polarity.
  localparam logic [DIGITS-1:0] AN_OFF =
    (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam seg_t SEG_OFF =
    (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic DP_OFF = (SEG_ACTIVE_LOW != 0);

  logic [PW-1:0]       r_pre;
  logic [IW-1:0]       r_idx;
  logic [4*DIGITS-1:0] r_pend_dig;
  logic [DIGITS-1:0]   r_pend_dp;
  logic                r_pend;
  logic [4*DIGITS-1:0] r_disp_dig;
  logic [DIGITS-1:0]   r_disp_dp;

  logic                w_tick;
  logic                w_bound;
  logic [3:0]          w_nib;
  seg_t                w_seg;
  logic [DIGITS-1:0]   w_onehot;
  logic                w_blank;

  assign w_tick   = (r_pre == PRE_MAX);
  assign w_bound  = w_tick && (r_idx == IDX_MAX);
  assign w_nib    = r_disp_dig[4*r_idx +: 4];
  assign w_onehot = DIGITS'(1) << r_idx;

  hex_to_seg7 u_dec (
    .i_nib (w_nib),
    .o_seg (w_seg)
  );

`ifdef SEG7_SCAN_LZB_EN
  logic [DIGITS-1:0] w_keep;

  // Keep a slot lit if it or any more-significant digit is nonzero.
  always_comb begin : lzb
    logic v_nz;
    v_nz   = 1'b0;
    w_keep = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      v_nz      = v_nz | (r_disp_dig[4*i +: 4] != 4'h0);
      w_keep[i] = v_nz | (i == 0);
    end
  end

  assign w_blank = ~w_keep[r_idx];
`else
  assign w_blank = 1'b0;
`endif

  // Prescaler and digit index walk the anodes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pre <= '0;
      r_idx <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
      r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + IW'(1);
    end else begin
      r_pre <= r_pre + PW'(1);
    end
  end

  // Pending/display pair: display only changes on a frame boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend_dig <= '0;
      r_pend_dp  <= '0;
      r_pend     <= 1'b0;
      r_disp_dig <= '0;
      r_disp_dp  <= '0;
    end else begin
      if (load) begin
        r_pend_dig <= digits_in;
        r_pend_dp  <= dp_in;
      end
      if (w_bound) begin
        r_pend <= 1'b0;
        if (load) begin
          r_disp_dig <= digits_in;
          r_disp_dp  <= dp_in;
        end else if (r_pend) begin
          r_disp_dig <= r_pend_dig;
          r_disp_dp  <= r_pend_dp;
        end
      end else if (load) begin
        r_pend <= 1'b1;
      end
    end
  end

  // Pin registers: polarity applied here, anode and segments switch together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an         <= AN_OFF;
      seg        <= SEG_OFF;
      dp         <= DP_OFF;
      frame_done <= 1'b0;
    end else begin
      an         <= (w_blank ? '0 : w_onehot) ^ AN_OFF;
      seg        <= (w_blank ? SEG_BLANK : w_seg) ^ SEG_OFF;
      dp         <= (~w_blank & r_disp_dp[r_idx]) ^ DP_OFF;
      frame_done <= w_bound;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: randomized and directed bench for seg7_scan.
// Reference model works from edge counts since reset release.
module tb_seg7_scan;

  localparam int D  = 4;
  localparam int R  = 4;
  localparam int FR = D * R;

`ifdef SEG7_SCAN_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  localparam logic [6:0] LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int checks = 0;
  int failures = 0;

  int          k;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_dp, m_pdp;
  bit          m_pv;

  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp, e_fd;

  always #5 clk = ~clk;

  seg7_scan #(
    .DIGITS         (D),
    .REFRESH_DIV    (R),
    .SEG_ACTIVE_LOW (1),
    .AN_ACTIVE_LOW  (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .load       (load),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  task automatic model_clear();
    k = 0;
    m_disp = '0;
    m_pend = '0;
    m_dp = '0;
    m_pdp = '0;
    m_pv = 1'b0;
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  // One clock: drive, predict pins from pre-edge model, then advance model.
  task automatic cyc(input logic ld, input logic [15:0] d,
                     input logic [3:0] p);
    int s;
    logic bl;
    load = ld;
    digits_in = d;
    dp_in = p;
    @(posedge clk);
    k++;
    s = ((k - 1) / R) % D;
    bl = LZB && (s > 0) && ((m_disp >> (4 * s)) == 16'h0);
    e_an  = bl ? 4'hF : ~(4'b0001 << s);
    e_seg = bl ? 7'h7F : ~LUT[m_disp[4*s +: 4]];
    e_dp  = bl ? 1'b1 : ~m_dp[s];
    e_fd  = (k % FR == 0);
    if (k % FR == 0) begin
      if (ld) begin
        m_disp = d;
        m_dp = p;
      end else if (m_pv) begin
        m_disp = m_pend;
        m_dp = m_pdp;
      end
      m_pv = 1'b0;
    end else if (ld) begin
      m_pend = d;
      m_pdp = p;
      m_pv = 1'b1;
    end
    #1;
    load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    if ({an, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset got an=%b seg=%h dp=%b fd=%b want 1111/7f/1/0",
               an, seg, dp, frame_done);
    end
    checks++;
    release_reset();
  endtask

  task automatic test_idle();
    int nfd = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1'b0, 16'h0, 4'h0);
      if (frame_done === 1'b1) nfd++;
      if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
        failures++;
        $display("FAIL idle k=%0d got %b/%h/%b/%b want %b/%h/%b/%b",
                 k, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
      end
      checks++;
      if (i == 0) begin
        if ({an, seg} !== {4'b1110, 7'h40}) begin
          failures++;
          $display("FAIL first_slot got an=%b seg=%h want 1110/40", an, seg);
        end
        checks++;
      end
    end
    if (nfd !== 2) begin
      failures++;
      $display("FAIL fd_count got %0d want 2", nfd);
    end
    checks++;
  endtask

  task automatic test_load_midframe();
    logic [6:0] want [4] = '{7'h78, 7'h40, 7'h08, 7'h79};
    int nb = -1;
    for (int i = 0; i < 48; i++) begin
      bit ld = (nb < 0) && (k % FR == 5);
      cyc(ld, 16'h1A07, 4'h0);
      if (ld) nb = ((k + FR - 1) / FR) * FR;
      if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
        failures++;
        $display("FAIL midload k=%0d got %b/%h/%b/%b want %b/%h/%b/%b",
                 k, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
      end
      checks++;
      if (nb > 0 && k > nb && k <= nb + FR && (k - nb - 1) % R == 0) begin
        if (seg !== want[(k - nb - 1) / R]) begin
          failures++;
          $display("FAIL midload_glyph k=%0d got seg=%h want %h",
                   k, seg, want[(k - nb - 1) / R]);
        end
        checks++;
      end
    end
  endtask

  task automatic test_two_loads();
    bit got1 = 1'b0;
    int nb = -1;
    for (int i = 0; i < 56; i++) begin
      bit ld = 1'b0;
      logic [15:0] d = 16'h0;
      if (nb < 0 && !got1 && k % FR == 2) begin
        ld = 1'b1;
        d = 16'h1111;
      end else if (nb < 0 && got1 && k % FR == 8) begin
        ld = 1'b1;
        d = 16'h2222;
      end
      cyc(ld, d, 4'h0);
      if (ld && d == 16'h1111) got1 = 1'b1;
      if (ld && d == 16'h2222) nb = ((k + FR - 1) / FR) * FR;
      if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
        failures++;
        $display("FAIL twoload k=%0d got %b/%h/%b/%b want %b/%h/%b/%b",
                 k, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
      end
      checks++;
      if (nb > 0 && k > nb && k <= nb + FR) begin
        if (seg !== 7'h24) begin
          failures++;
          $display("FAIL twoload_glyph k=%0d got seg=%h want 24", k, seg);
        end
        checks++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int nb = -1;
    for (int i = 0; i < 40; i++) begin
      bit ld = (nb < 0) && (k % FR == FR - 1);
      cyc(ld, 16'h8888, 4'h0);
      if (ld) nb = k;
      if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
        failures++;
        $display("FAIL bndload k=%0d got %b/%h/%b/%b want %b/%h/%b/%b",
                 k, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
      end
      checks++;
      if (nb > 0 && k > nb && k <= nb + FR) begin
        if (seg !== 7'h00) begin
          failures++;
          $display("FAIL bndload_glyph k=%0d got seg=%h want 00", k, seg);
        end
        checks++;
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bit ld = ($urandom_range(0, 5) == 0);
      logic [15:0] d = 16'($urandom);
      logic [3:0]  p = 4'($urandom);
      if ($urandom_range(0, 3) == 0) d[15:8] = 8'h00;
      cyc(ld, d, p);
      if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
        failures++;
        $display("FAIL random k=%0d got %b/%h/%b/%b want %b/%h/%b/%b",
                 k, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
      end
      checks++;
    end
  endtask

  task automatic test_reset_midscan();
    int n = 0;
    cyc(1'b1, 16'h4321, 4'h5);
    while (((k - 1) / R) % D != 2 && n < 2 * FR) begin
      cyc(1'b0, 16'h0, 4'h0);
      n++;
    end
    if (((k - 1) / R) % D != 2) begin
      failures++;
      $display("FAIL slot2_reach got slot %0d want 2", ((k - 1) / R) % D);
    end
    checks++;
    #2;
    reset = 1'b1;
    #1;
    if ({an, seg, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL async_reset got an=%b seg=%h dp=%b fd=%b want 1111/7f/1/0",
               an, seg, dp, frame_done);
    end
    checks++;
    release_reset();
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 16'h0, 4'h0);
      if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
        failures++;
        $display("FAIL postreset k=%0d got %b/%h/%b/%b want %b/%h/%b/%b",
                 k, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
      end
      checks++;
      if (i == 0) begin
        if ({an, seg} !== {4'b1110, 7'h40}) begin
          failures++;
          $display("FAIL restart got an=%b seg=%h want 1110/40", an, seg);
        end
        checks++;
      end
    end
  endtask

`ifdef SEG7_SCAN_LZB_EN
  task automatic test_lzb();
    int nb = -1;
    for (int i = 0; i < 80; i++) begin
      bit ld = 1'b0;
      logic [15:0] d = 16'h0;
      if (nb < 0 && k % FR == 3) begin
        ld = 1'b1;
        d = 16'h0050;
      end
      if (nb > 0 && k == nb + FR + 3) begin
        ld = 1'b1;
        d = 16'h0000;
      end
      cyc(ld, d, 4'h0);
      if (ld && d == 16'h0050) nb = ((k + FR - 1) / FR) * FR;
      if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
        failures++;
        $display("FAIL lzb k=%0d got %b/%h/%b/%b want %b/%h/%b/%b",
                 k, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
      end
      checks++;
      if (nb > 0 && k > nb && k <= nb + FR && ((k - nb - 1) / R) >= 2) begin
        if (an !== 4'hF) begin
          failures++;
          $display("FAIL lzb_blank k=%0d got an=%b want 1111", k, an);
        end
        checks++;
      end
      if (nb > 0 && k > nb + 2 * FR && k <= nb + 3 * FR &&
          ((k - nb - 1) / R) % D != 0) begin
        if (an !== 4'hF) begin
          failures++;
          $display("FAIL lzb_zero k=%0d got an=%b want 1111", k, an);
        end
        checks++;
      end
    end
  endtask
`endif

  initial begin
    model_clear();
    test_reset();
    test_idle();
    test_load_midframe();
    test_two_loads();
    test_back_to_back();
    test_random();
    test_reset_midscan();
`ifdef SEG7_SCAN_LZB_EN
    test_lzb();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
